urv_dm_wb_bridge: RTL and testbench

Data-memory responder for the uRV core. It accepts the single-cycle load/store requests the execute stage issues on its data-memory interface and runs them as Wishbone B4 pipelined master cycles. It returns load data and completion pulses to the writeback stage, with optional posted stores and a bus timeout. The bridge sits between the core's `dm_*` port and the system interconnect.

---
 rtl/urv_dm_wb_bridge_pkg.sv | 19 +
 rtl/urv_dm_wb_bridge_timeout.sv | 53 +++++
 rtl/urv_dm_wb_bridge.sv | 171 +++++++++++++++++
 tb/tb_urv_dm_wb_bridge.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/urv_dm_wb_bridge_pkg.sv
// Shared definitions for the uRV data-memory to Wishbone bridge.
//   bridge_state_t   : FSM state encodings (IDLE / REQ / WAIT)
//   URV_BUS_ERR_DATA : load data returned when an access ends on err or timeout
//   word_align()     : clears the byte-offset bits of a byte address
package urv_dm_wb_bridge_pkg;

  typedef enum logic [1:0] {
    BRIDGE_IDLE = 2'd0,
    BRIDGE_REQ  = 2'd1,
    BRIDGE_WAIT = 2'd2
  } bridge_state_t;

  localparam logic [31:0] URV_BUS_ERR_DATA = 32'h0000_0000;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/urv_dm_wb_bridge_timeout.sv
// urv_bus_timeout: saturating bus-cycle counter for the data-memory bridge.
//   clk_i, rst_n_i : clock, asynchronous active-low reset
//   clr_i          : restart counting from zero (a new access was accepted)
//   en_i           : count this cycle (bus cycle in progress)
//   expired_o      : the count reaches g_timeout at the coming clock edge
// With g_timeout = 0 the counter is removed and expired_o is tied low.
module urv_bus_timeout
  import urv_dm_wb_bridge_pkg::*;
#(
  parameter int g_timeout = 255
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  if (g_timeout == 0) begin : g_off
    logic unused_inputs;
    assign unused_inputs = &{1'b0, clk_i, rst_n_i, clr_i, en_i};
    assign expired_o     = 1'b0;
  end else begin : g_on
    localparam int            CW    = $clog2(g_timeout + 1);
    localparam logic [CW-1:0] LIMIT = CW'(g_timeout);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Saturates at LIMIT so a long-stalled cycle can never wrap back to zero.
    always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
        cnt_d = '0;
      end else if (en_i && (cnt_q != LIMIT)) begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    // Looks at the next count so the access ends on the edge the limit is hit,
    // giving exactly g_timeout cycles of cyc.
    assign expired_o = en_i && !clr_i && (cnt_d == LIMIT);
  end

endmodule

// File: rtl/urv_dm_wb_bridge.sv
// urv_dm_wb_bridge: runs the uRV core's single-cycle data-memory requests as
// Wishbone B4 pipelined master cycles and returns completion pulses.
//   clk_i, rst_n_i      : clock, asynchronous active-low reset
//   dm_addr_i           : byte address
//   dm_data_s_i         : store data (lane-replicated)
//   dm_data_select_i    : byte-lane enables
//   dm_load_i/store_i   : request pulses, honoured only while dm_ready_o = 1
//   dm_ready_o          : bridge can take a request this cycle
//   dm_data_l_o         : load data, valid with dm_load_done_o
//   dm_load_done_o      : load completion pulse
//   dm_store_done_o     : store completion pulse (posted or on termination)
//   dm_bus_error_o      : access ended on err or timeout
//   wb_*                : Wishbone B4 pipelined master port
module urv_dm_wb_bridge
  import urv_dm_wb_bridge_pkg::*;
#(
  parameter int g_timeout       = 255,
  parameter int g_posted_stores = 1
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_data_s_i,
  input  logic [3:0]  dm_data_select_i,
  input  logic        dm_load_i,
  input  logic        dm_store_i,
  output logic        dm_ready_o,
  output logic [31:0] dm_data_l_o,
  output logic        dm_load_done_o,
  output logic        dm_store_done_o,
  output logic        dm_bus_error_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  input  logic        wb_stall_i
);

  bridge_state_t state_q, state_d;

  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic [3:0]  sel_q, sel_d;
  logic        we_q, we_d;
  logic [31:0] data_l_q, data_l_d;
  logic        load_done_q, load_done_d;
  logic        store_done_q, store_done_d;
  logic        bus_error_q, bus_error_d;
  // High in the cycle after termination; keeps dm_ready_o low in the done cycle.
  logic        term_q, term_d;

  logic busy;
  logic accept;
  logic tmo_expired;
  logic term;
  logic term_err;

  assign busy     = (state_q != BRIDGE_IDLE);
  assign accept   = dm_ready_o && (dm_load_i || dm_store_i);
  assign term     = busy && (wb_ack_i || wb_err_i || tmo_expired);
  // err outranks a simultaneous ack; a timeout is always an error.
  assign term_err = wb_err_i || tmo_expired;

  urv_bus_timeout #(
    .g_timeout (g_timeout)
  ) u_timeout (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .clr_i     (accept),
    .en_i      (busy),
    .expired_o (tmo_expired)
  );

  always_comb begin
    state_d      = state_q;
    adr_d        = adr_q;
    dat_d        = dat_q;
    sel_d        = sel_q;
    we_d         = we_q;
    data_l_d     = data_l_q;
    load_done_d  = 1'b0;
    store_done_d = 1'b0;
    bus_error_d  = 1'b0;
    term_d       = 1'b0;

    case (state_q)
      BRIDGE_IDLE: begin
        if (accept) begin
          adr_d   = word_align(dm_addr_i);
          dat_d   = dm_data_s_i;
          sel_d   = dm_data_select_i;
          // A load pulsed together with a store wins; the store is dropped.
          we_d    = !dm_load_i;
          state_d = BRIDGE_REQ;
          if (!dm_load_i && (g_posted_stores != 0)) begin
            store_done_d = 1'b1;
          end
        end
      end
      BRIDGE_REQ: begin
        if (!wb_stall_i) begin
          state_d = BRIDGE_WAIT;
        end
      end
      BRIDGE_WAIT: begin
        state_d = BRIDGE_WAIT;
      end
      default: begin
        state_d = BRIDGE_IDLE;
      end
    endcase

    // Termination overrides the REQ->WAIT step so zero-wait slaves finish in REQ.
    if (term) begin
      state_d     = BRIDGE_IDLE;
      term_d      = 1'b1;
      bus_error_d = term_err;
      if (!we_q) begin
        load_done_d = 1'b1;
        data_l_d    = term_err ? URV_BUS_ERR_DATA : wb_dat_i;
      end else if (g_posted_stores == 0) begin
        store_done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= BRIDGE_IDLE;
      adr_q        <= '0;
      dat_q        <= '0;
      sel_q        <= '0;
      we_q         <= 1'b0;
      data_l_q     <= '0;
      load_done_q  <= 1'b0;
      store_done_q <= 1'b0;
      bus_error_q  <= 1'b0;
      term_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      adr_q        <= adr_d;
      dat_q        <= dat_d;
      sel_q        <= sel_d;
      we_q         <= we_d;
      data_l_q     <= data_l_d;
      load_done_q  <= load_done_d;
      store_done_q <= store_done_d;
      bus_error_q  <= bus_error_d;
      term_q       <= term_d;
    end
  end

  // cyc/stb decode the state register, so reset drops them without a clock edge.
  assign wb_cyc_o        = busy;
  assign wb_stb_o        = (state_q == BRIDGE_REQ);
  assign wb_adr_o        = adr_q;
  assign wb_dat_o        = dat_q;
  assign wb_sel_o        = sel_q;
  assign wb_we_o         = we_q;
  assign dm_ready_o      = (state_q == BRIDGE_IDLE) && !term_q;
  assign dm_data_l_o     = data_l_q;
  assign dm_load_done_o  = load_done_q;
  assign dm_store_done_o = store_done_q;
  assign dm_bus_error_o  = bus_error_q;

endmodule

// File: tb/tb_urv_dm_wb_bridge.sv
// Bench for urv_dm_wb_bridge. Two instances share every input:
//   index 0: g_timeout = 255, posted stores
//   index 1: g_timeout = 4,   stores complete on termination
// A scripted slave drives stall/ack/err relative to the request edge, and the
// expected per-cycle outputs come from transaction-level rules (bus length,
// termination cycle, error flag) rather than from a copy of the FSM.
module tb_urv_dm_wb_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] dm_addr_i;
  logic [31:0] dm_data_s_i;
  logic [3:0]  dm_data_select_i;
  logic        dm_load_i;
  logic        dm_store_i;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;
  logic        wb_err_i;
  logic        wb_stall_i;

  logic [31:0] o_adr [2];
  logic [31:0] o_dat [2];
  logic [31:0] o_dl  [2];
  logic [3:0]  o_sel [2];
  logic        o_we  [2];
  logic        o_cyc [2];
  logic        o_stb [2];
  logic        o_rdy [2];
  logic        o_ld  [2];
  logic        o_sd  [2];
  logic        o_be  [2];

  logic [31:0] exp_dl [2];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  urv_dm_wb_bridge #(.g_timeout(255), .g_posted_stores(1)) u_dut_a (
    .clk_i(clk), .rst_n_i(rst_n),
    .dm_addr_i(dm_addr_i), .dm_data_s_i(dm_data_s_i), .dm_data_select_i(dm_data_select_i),
    .dm_load_i(dm_load_i), .dm_store_i(dm_store_i), .dm_ready_o(o_rdy[0]),
    .dm_data_l_o(o_dl[0]), .dm_load_done_o(o_ld[0]), .dm_store_done_o(o_sd[0]),
    .dm_bus_error_o(o_be[0]), .wb_adr_o(o_adr[0]), .wb_dat_o(o_dat[0]), .wb_sel_o(o_sel[0]),
    .wb_we_o(o_we[0]), .wb_cyc_o(o_cyc[0]), .wb_stb_o(o_stb[0]),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_stall_i(wb_stall_i)
  );

  urv_dm_wb_bridge #(.g_timeout(4), .g_posted_stores(0)) u_dut_b (
    .clk_i(clk), .rst_n_i(rst_n),
    .dm_addr_i(dm_addr_i), .dm_data_s_i(dm_data_s_i), .dm_data_select_i(dm_data_select_i),
    .dm_load_i(dm_load_i), .dm_store_i(dm_store_i), .dm_ready_o(o_rdy[1]),
    .dm_data_l_o(o_dl[1]), .dm_load_done_o(o_ld[1]), .dm_store_done_o(o_sd[1]),
    .dm_bus_error_o(o_be[1]), .wb_adr_o(o_adr[1]), .wb_dat_o(o_dat[1]), .wb_sel_o(o_sel[1]),
    .wb_we_o(o_we[1]), .wb_cyc_o(o_cyc[1]), .wb_stb_o(o_stb[1]),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_stall_i(wb_stall_i)
  );

  function automatic int tmo_of(input int d);
    return (d == 0) ? 255 : 4;
  endfunction

  function automatic bit posted_of(input int d);
    return (d == 0);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Idle/reset view of one instance: no bus cycle, ready, no pulses.
  task automatic chk_idle(input string nm, input int d, input logic [31:0] xadr);
    chk($sformatf("%s d%0d cyc", nm, d), o_cyc[d], 0);
    chk($sformatf("%s d%0d stb", nm, d), o_stb[d], 0);
    chk($sformatf("%s d%0d rdy", nm, d), o_rdy[d], 1);
    chk($sformatf("%s d%0d ld", nm, d), o_ld[d], 0);
    chk($sformatf("%s d%0d sd", nm, d), o_sd[d], 0);
    chk($sformatf("%s d%0d be", nm, d), o_be[d], 0);
    chk($sformatf("%s d%0d adr", nm, d), o_adr[d], xadr);
    chk($sformatf("%s d%0d dl", nm, d), o_dl[d], exp_dl[d]);
  endtask

  // Cycle k counts from 1 = first cycle after the request edge. The access
  // holds cyc for L cycles, the done cycle is L+1, ready returns at L+2.
  task automatic chk_cycle(input string nm, input int d, input int k, input int L,
                           input bit ef, input bit eld, input bit est, input int S,
                           input logic [31:0] xadr, input logic [31:0] xdat,
                           input logic [3:0] xsel, input logic [31:0] rcap);
    string t;
    bit xcyc, xstb, xrdy, xld, xsd, xbe;
    t    = $sformatf("%s d%0d k%0d", nm, d, k);
    xcyc = (k <= L);
    xstb = (k <= L) && (k <= S + 1);
    xrdy = (k >= L + 2);
    xld  = (k == L + 1) && eld;
    xsd  = est && ((k == 1 && posted_of(d)) || (k == L + 1 && !posted_of(d)));
    xbe  = (k == L + 1) && ef;
    if (xld) exp_dl[d] = ef ? 32'h0 : rcap;
    chk({t, " cyc"}, o_cyc[d], xcyc);
    chk({t, " stb"}, o_stb[d], xstb);
    chk({t, " rdy"}, o_rdy[d], xrdy);
    chk({t, " ld"},  o_ld[d],  xld);
    chk({t, " sd"},  o_sd[d],  xsd);
    chk({t, " be"},  o_be[d],  xbe);
    chk({t, " dl"},  o_dl[d],  exp_dl[d]);
    chk({t, " adr"}, o_adr[d], xadr);
    chk({t, " dat"}, o_dat[d], xdat);
    chk({t, " sel"}, o_sel[d], xsel);
    chk({t, " we"},  o_we[d],  est);
  endtask

  // resp: 0 ack, 1 err, 2 ack+err, 3 no response. The slave stalls the strobe
  // S cycles and answers W cycles after it is consumed. A stray store request
  // is pulsed in the first cycle where neither instance may take it.
  task automatic run_txn(input string nm, input bit ld, input bit st,
                         input logic [31:0] addr, input logic [31:0] sdat,
                         input logic [3:0] sel, input int S, input int W, input int resp,
                         input bit fix_rd, input logic [31:0] rd_fixed);
    int Lr, K, pk;
    int L [2];
    bit ef [2];
    bit eld, est, to;
    logic [31:0] rcap, xadr;
    Lr   = S + 1 + W;
    eld  = ld;
    est  = st && !ld;
    xadr = {addr[31:2], 2'b00};
    for (int d = 0; d < 2; d++) begin
      to    = (resp == 3) || (tmo_of(d) <= Lr);
      L[d]  = to ? tmo_of(d) : Lr;
      ef[d] = to || (resp == 1) || (resp == 2);
    end
    K    = ((L[0] > L[1]) ? L[0] : L[1]) + 2;
    pk   = ((L[0] < L[1]) ? L[0] : L[1]) + 1;
    rcap = 32'h0;

    dm_addr_i        = addr;
    dm_data_s_i      = sdat;
    dm_data_select_i = sel;
    dm_load_i        = ld;
    dm_store_i       = st;
    @(posedge clk);
    for (int k = 1; k <= K; k++) begin
      @(negedge clk);
      if (k == 1) begin
        dm_load_i        = 1'b0;
        dm_addr_i        = $urandom;
        dm_data_s_i      = $urandom;
        dm_data_select_i = 4'($urandom);
      end
      dm_store_i = (k == pk);
      for (int d = 0; d < 2; d++)
        chk_cycle(nm, d, k, L[d], ef[d], eld, est, S, xadr, sdat, sel, rcap);
      wb_dat_i   = (fix_rd && k == Lr) ? rd_fixed : $urandom;
      wb_stall_i = (k <= S);
      wb_ack_i   = (k == Lr) && (resp == 0 || resp == 2);
      wb_err_i   = (k == Lr) && (resp == 1 || resp == 2);
      if (k == Lr) rcap = wb_dat_i;
    end
    dm_store_i = 1'b0;
    wb_ack_i   = 1'b0;
    wb_err_i   = 1'b0;
    wb_stall_i = 1'b0;
  endtask

  initial begin
    bit ld, st;
    int s, w, r;
    logic [31:0] lane;
    rst_n            = 1'b0;
    dm_addr_i        = '0;
    dm_data_s_i      = '0;
    dm_data_select_i = '0;
    dm_load_i        = 1'b0;
    dm_store_i       = 1'b0;
    wb_dat_i         = '0;
    wb_ack_i         = 1'b0;
    wb_err_i         = 1'b0;
    wb_stall_i       = 1'b0;
    exp_dl[0]        = '0;
    exp_dl[1]        = '0;

    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk_idle("reset", d, 32'h0);
      chk($sformatf("reset d%0d we", d), o_we[d], 0);
      chk($sformatf("reset d%0d sel", d), o_sel[d], 0);
      chk($sformatf("reset d%0d dat", d), o_dat[d], 0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    run_txn("zw_load",     1'b1, 1'b0, 32'h0000_0100, 32'h1234_5678, 4'hF, 0, 0, 0, 1'b1, 32'hCAFE_F00D);
    run_txn("stall_store", 1'b0, 1'b1, 32'h0000_0203, 32'h5555_5555, 4'b1000, 3, 2, 0, 1'b0, 32'h0);
    run_txn("ack_err",     1'b1, 1'b0, 32'h0000_0400, 32'h0, 4'hF, 0, 1, 2, 1'b0, 32'h0);
    run_txn("no_resp",     1'b1, 1'b0, 32'h0000_0500, 32'h0, 4'hF, 0, 0, 3, 1'b0, 32'h0);
    run_txn("after_tmo",   1'b1, 1'b0, 32'h0000_0504, 32'h0, 4'hF, 0, 0, 0, 1'b1, 32'h0BAD_F00D);
    run_txn("both_req",    1'b1, 1'b1, 32'h0000_0608, 32'hA5A5_A5A5, 4'hF, 1, 0, 0, 1'b0, 32'h0);
    run_txn("err_store",   1'b0, 1'b1, 32'h0000_070C, 32'h3C3C_3C3C, 4'b0011, 0, 2, 1, 1'b0, 32'h0);

    for (int i = 0; i < 8; i++) begin
      ld   = 1'($urandom_range(0, 1));
      st   = !ld || ($urandom_range(0, 3) == 0);
      s    = $urandom_range(0, 2);
      w    = $urandom_range(0, 2);
      if (s + 1 + w == 4) w++;
      r    = $urandom_range(0, 2);
      lane = {4{8'($urandom)}};
      run_txn($sformatf("rnd%0d", i), ld, st, $urandom, lane, 4'($urandom_range(1, 15)),
              s, w, r, 1'b0, 32'h0);
    end

    // Reset while both instances sit in WAIT on an unanswered load.
    dm_addr_i        = 32'h0000_0800;
    dm_data_select_i = 4'hF;
    dm_load_i        = 1'b1;
    @(posedge clk);
    @(negedge clk);
    dm_load_i = 1'b0;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) chk($sformatf("pre_rst d%0d cyc", d), o_cyc[d], 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("async_rst d%0d cyc", d), o_cyc[d], 0);
      chk($sformatf("async_rst d%0d stb", d), o_stb[d], 0);
    end
    exp_dl[0] = '0;
    exp_dl[1] = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) chk_idle("post_rst", d, 32'h0);
    end
    run_txn("post_rst_load", 1'b1, 1'b0, 32'h0000_0904, 32'h0, 4'hF, 0, 1, 0, 1'b1, 32'h600D_D00D);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
